lzma_input_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares the single 8-bit AXI-stream input of the LZMA compressor among up to eight independent byte-stream sources. A grant is locked to one source from its first beat until the beat carrying tlast is accepted, so streams are never interleaved. The arbiter sits directly in front of the compressor input. It drives a registered output stage together with a source-ID tag, so downstream logic can attribute each compressed stream to its origin.

---
 rtl/lzma_arb_pkg.sv | 6 +
 rtl/lzma_arb_rr_pick.sv | 25 ++
 rtl/lzma_input_arbiter.sv | 97 +++++++++
 tb/tb_lzma_input_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lzma_arb_pkg.sv
// lzma_arb_pkg: shared FSM encoding and constants for the LZMA input arbiter
package lzma_arb_pkg;
  typedef enum logic {IDLE = 1'b0, PASS = 1'b1} arb_state_t;
  localparam int MAX_SRC = 8;
  localparam int STAT_W = 32;
endpackage

// File: rtl/lzma_arb_rr_pick.sv
// lzma_arb_rr_pick: combinational round-robin pick, searching upward from last+1 with wrap
module lzma_arb_rr_pick #(
  parameter int N_SRC = 4,
  parameter int ID_W  = 3
) (
  input  logic [N_SRC-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic             any,
  output logic [ID_W-1:0]  idx
);
  logic [2*N_SRC-1:0] dbl;
  logic [N_SRC-1:0]   rot;
  assign dbl = {req, req};
  // rot[k] is the request k+1 positions after last
  assign rot = N_SRC'(dbl >> (int'(last) + 1));
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = N_SRC - 1; k >= 0; k--)
      if (rot[k]) begin
        any = 1'b1;
        idx = ID_W'((int'(last) + 1 + k) % N_SRC);
      end
  end
endmodule

// File: rtl/lzma_input_arbiter.sv
// lzma_input_arbiter: packet-locked round-robin arbiter feeding the LZMA compressor input
// Define LZMA_ARB_STATS_EN to add the stat_pkts/stat_bytes counters.
module lzma_input_arbiter import lzma_arb_pkg::*; #(
  parameter int N_SRC = 4,
  parameter int ID_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_SRC-1:0]   s_tvalid,
  output logic [N_SRC-1:0]   s_tready,
  input  logic [8*N_SRC-1:0] s_tdata,
  input  logic [N_SRC-1:0]   s_tlast,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic [7:0]         m_tdata,
  output logic               m_tlast,
  output logic [ID_W-1:0]    m_tid,
  output logic               busy
`ifdef LZMA_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]  stat_pkts,
  output logic [STAT_W-1:0]  stat_bytes
`endif
);
  arb_state_t state, state_n;
  logic [ID_W-1:0] grant, grant_n, last_grant, last_grant_n, pick;
  logic pick_any, sel_valid, sel_last, out_ok, accept;
  logic [7:0] sel_data;
  lzma_arb_rr_pick #(.N_SRC(N_SRC), .ID_W(ID_W)) u_pick (
    .req(s_tvalid),
    .last(last_grant),
    .any(pick_any),
    .idx(pick)
  );
  always_comb begin
    sel_valid = 1'b0;
    sel_last = 1'b0;
    sel_data = '0;
    for (int i = 0; i < N_SRC; i++)
      if (grant == ID_W'(i)) begin
        sel_valid = s_tvalid[i];
        sel_last = s_tlast[i];
        sel_data = s_tdata[8*i +: 8];
      end
  end
  assign out_ok = ~m_tvalid | m_tready;
  assign s_tready = (state == PASS && out_ok) ? N_SRC'(1) << grant : '0;
  assign accept = state == PASS && sel_valid && out_ok;
  assign busy = state == PASS || m_tvalid;
  always_comb begin
    state_n = state;
    grant_n = grant;
    last_grant_n = last_grant;
    if (state == IDLE) begin
      state_n = pick_any ? PASS : IDLE;
      grant_n = pick_any ? pick : grant;
    end else if (accept && sel_last) begin
      state_n = IDLE;
      last_grant_n = grant;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      last_grant <= ID_W'(N_SRC - 1);
    end else begin
      state <= state_n;
      grant <= grant_n;
      last_grant <= last_grant_n;
    end
  // a pop and a fresh accept in one cycle keep m_tvalid high with the new beat
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      m_tvalid <= 1'b0;
      m_tdata <= '0;
      m_tlast <= 1'b0;
      m_tid <= '0;
    end else if (accept) begin
      m_tvalid <= 1'b1;
      m_tdata <= sel_data;
      m_tlast <= sel_last;
      m_tid <= grant;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
`ifdef LZMA_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stat_pkts <= '0;
      stat_bytes <= '0;
    end else if (m_tvalid && m_tready) begin
      stat_bytes <= stat_bytes + 1'b1;
      stat_pkts <= stat_pkts + STAT_W'(m_tlast);
    end
`endif
endmodule

// File: tb/tb_lzma_input_arbiter.sv
// tb_lzma_input_arbiter: directed and randomized checks against a beat-queue reference model
module tb_lzma_input_arbiter;
  localparam int N = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] s_tvalid, s_tready, s_tlast;
  logic [8*N-1:0] s_tdata;
  logic m_tvalid, m_tready, m_tlast, busy;
  logic [7:0] m_tdata;
  logic [2:0] m_tid;
`ifdef LZMA_ARB_STATS_EN
  logic [31:0] stat_pkts, stat_bytes;
`endif
  always #5 clk = ~clk;

  lzma_input_arbiter #(.N_SRC(N), .ID_W(3)) dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .m_tid(m_tid), .busy(busy)
`ifdef LZMA_ARB_STATS_EN
    , .stat_pkts(stat_pkts), .stat_bytes(stat_bytes)
`endif
  );

  int nvec = 0, nerr = 0;
  logic [8:0] src_q [N][$];
  bit hold [N];
  int gap_pct = 0, rdy_pct = 100;
  int owner = -1, lastg = N - 1, oid = 0, beats_out = 0, pushed = 0;
  bit ov = 0, ol = 0;
  logic [7:0] od = '0;
  logic [31:0] mp = '0, mb = '0;
  int order [$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_stream(int s, int first, int len);
    for (int j = 0; j < len; j++) src_q[s].push_back({1'(j == len - 1), 8'(first + j)});
    pushed += len;
  endtask

  task automatic drive();
    logic [8:0] h;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && !hold[i] && $urandom_range(99) >= gap_pct) begin
        h = src_q[i][0];
        s_tvalid[i] = 1'b1;
        s_tdata[8*i +: 8] = h[7:0];
        s_tlast[i] = h[8];
      end else begin
        s_tvalid[i] = 1'b0;
        s_tdata[8*i +: 8] = 8'($urandom);
        s_tlast[i] = 1'($urandom);
      end
    end
    m_tready = $urandom_range(99) < rdy_pct;
  endtask

  task automatic check_out();
    chk("m_tvalid", m_tvalid, ov);
    chk("m_tdata", m_tdata, od);
    chk("m_tlast", m_tlast, ol);
    chk("m_tid", m_tid, oid);
    chk("busy", busy, owner >= 0 || ov);
`ifdef LZMA_ARB_STATS_EN
    chk("stat_pkts", stat_pkts, mp);
    chk("stat_bytes", stat_bytes, mb);
`endif
  endtask

  // one clock: check current outputs, advance the model across the edge, drive next inputs
  task automatic tick();
    logic [N-1:0] exp_rdy;
    logic [8:0] b;
    bit mr, acc;
    @(negedge clk);
    check_out();
    mr = owner >= 0 && (!ov || m_tready);
    exp_rdy = '0;
    if (mr) exp_rdy[owner] = 1'b1;
    chk("s_tready", s_tready, exp_rdy);
    acc = mr && s_tvalid[owner];
    if (ov && m_tready) begin
      mb++;
      if (ol) mp++;
    end
    if (acc) begin
      b = src_q[owner].pop_front();
      ov = 1;
      od = b[7:0];
      ol = b[8];
      oid = owner;
      beats_out++;
      if (b[8]) begin
        order.push_back(owner);
        lastg = owner;
        owner = -1;
      end
    end else begin
      if (m_tready) ov = 0;
      if (owner < 0)
        for (int k = 1; k <= N; k++)
          if (s_tvalid[(lastg + k) % N]) begin
            owner = (lastg + k) % N;
            break;
          end
    end
    @(posedge clk);
    #1 drive();
  endtask

  function automatic bit pending();
    bit p = ov || owner >= 0;
    for (int i = 0; i < N; i++) if (src_q[i].size() > 0) p = 1;
    return p;
  endfunction

  task automatic drain(string tag, int budget);
    int c = 0;
    while (pending() && c < budget) begin
      tick();
      c++;
    end
    chk({tag, "_drained"}, 32'(c < budget), 1);
    chk({tag, "_beats"}, beats_out, pushed);
  endtask

  task automatic do_reset();
    #3 rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      hold[i] = 0;
    end
    owner = -1; lastg = N - 1; ov = 0; od = '0; ol = 0; oid = 0; mp = '0; mb = '0;
    beats_out = 0; pushed = 0;
    order.delete();
    drive();
    #1 check_out();
    chk("rst_s_tready", s_tready, 0);
    @(posedge clk);
    #4 rst = 1'b0;
    @(posedge clk);
    #1 drive();
  endtask

  initial begin
    for (int i = 0; i < N; i++) hold[i] = 0;
    drive();
    @(posedge clk);
    #1 check_out();
    chk("rst_s_tready", s_tready, 0);
    @(posedge clk);
    #4 rst = 1'b0;
    @(posedge clk);
    #1 drive();

    // source 2 alone, 5 bytes
    push_stream(2, 8'h10, 5);
    drive();
    drain("sc1", 100);
    chk("sc1_npkt", order.size(), 1);
    chk("sc1_tid", order[0], 2);

    // all sources contend with 3-byte streams, two rounds
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < N; s++) push_stream(s, 8'h40 + 16 * s + 4 * r, 3);
    drive();
    drain("sc2", 200);
    chk("sc2_npkt", order.size(), 8);
    for (int j = 0; j < 8; j++) chk("sc2_order", order[j], j % N);

    // source 1 stalls mid-stream while source 3 waits
    do_reset();
    push_stream(1, 8'h80, 4);
    drive();
    for (int c = 0; c < 3; c++) tick();
    hold[1] = 1;
    push_stream(3, 8'hA0, 2);
    drive();
    for (int c = 0; c < 10; c++) tick();
    chk("sc3_src3_wait", src_q[3].size(), 2);
    hold[1] = 0;
    drive();
    drain("sc3", 100);
    chk("sc3_order0", order[0], 1);
    chk("sc3_order1", order[1], 3);

    // output back-pressure for 7 cycles
    do_reset();
    push_stream(0, 8'hC0, 4);
    drive();
    for (int c = 0; c < 3; c++) tick();
    rdy_pct = 0;
    drive();
    for (int c = 0; c < 7; c++) tick();
    chk("sc4_held_tdata", m_tdata, 8'hC1);
    rdy_pct = 100;
    drive();
    drain("sc4", 100);

    // simultaneous single-byte streams from 0 and 3
    do_reset();
    push_stream(0, 8'h05, 1);
    push_stream(3, 8'h35, 1);
    drive();
    drain("sc5", 50);
    chk("sc5_npkt", order.size(), 2);
    chk("sc5_first", order[0], 0);
    chk("sc5_second", order[1], 3);

    // reset mid-stream, then source 1
    do_reset();
    push_stream(2, 8'h60, 8);
    drive();
    for (int c = 0; c < 5; c++) tick();
    do_reset();
    push_stream(1, 8'h70, 3);
    drive();
    drain("sc6", 50);
    chk("sc6_tid", order[0], 1);

    // randomized traffic with gaps and back-pressure
    do_reset();
    gap_pct = 30;
    rdy_pct = 70;
    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < N; s++)
        if ($urandom_range(3) != 0) push_stream(s, int'($urandom_range(255)), int'($urandom_range(1, 6)));
      drive();
      drain("rnd", 1000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
